// File: rtl/rib_sdram_wbuf_if.sv
// rtl/rib_sdram_wbuf_if.sv - RIB upstream/downstream signal bundle for the posted-write buffer
// Signal names follow the buffer's own port view: i_* enter the buffer, o_* leave it.
interface rib_sdram_wbuf_if #(
    parameter int AW = 32
) ();
    logic [AW-1:0] i_ribs_addr;
    logic          i_ribs_wrcs;
    logic [3:0]    i_ribs_mask;
    logic [31:0]   i_ribs_wdata;
    logic          i_ribs_req;
    logic          o_ribs_gnt;
    logic          o_ribs_rsp;
    logic [31:0]   o_ribs_rdata;
    logic          i_ribs_rdy;

    logic [AW-1:0] o_ribm_addr;
    logic          o_ribm_wrcs;
    logic [3:0]    o_ribm_mask;
    logic [31:0]   o_ribm_wdata;
    logic          o_ribm_req;
    logic          i_ribm_gnt;
    logic          i_ribm_rsp;
    logic [31:0]   i_ribm_rdata;
    logic          o_ribm_rdy;

    modport slave (
        input  i_ribs_addr, i_ribs_wrcs, i_ribs_mask, i_ribs_wdata, i_ribs_req, i_ribs_rdy,
        output o_ribs_gnt, o_ribs_rsp, o_ribs_rdata,
        output o_ribm_addr, o_ribm_wrcs, o_ribm_mask, o_ribm_wdata, o_ribm_req, o_ribm_rdy,
        input  i_ribm_gnt, i_ribm_rsp, i_ribm_rdata
    );

    modport master (
        output i_ribs_addr, i_ribs_wrcs, i_ribs_mask, i_ribs_wdata, i_ribs_req, i_ribs_rdy,
        input  o_ribs_gnt, o_ribs_rsp, o_ribs_rdata,
        input  o_ribm_addr, o_ribm_wrcs, o_ribm_mask, o_ribm_wdata, o_ribm_req, o_ribm_rdy,
        output i_ribm_gnt, i_ribm_rsp, i_ribm_rdata
    );
endinterface

// File: rtl/rib_sdram_wbuf.sv
// rtl/rib_sdram_wbuf.sv - posted-write buffer with read-after-write ordering in front of the SDRAM RIB slave
// Writes are acknowledged on entry to the FIFO; reads wait until the FIFO and drain FSM are idle.
module rib_sdram_wbuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rib_sdram_wbuf_if.slave      bus,
    output logic                 o_wbuf_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RSP,
        ST_RD_REQ,
        ST_RD_RSP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rsp_pend_q, rsp_pend_d;
    logic            ribs_rsp_q, ribs_rsp_d;
    logic [31:0]     ribs_rdata_q, ribs_rdata_d;
    logic [AW-1:0]   ribm_addr_q, ribm_addr_d;
    logic            ribm_wrcs_q, ribm_wrcs_d;
    logic [3:0]      ribm_mask_q, ribm_mask_d;
    logic [31:0]     ribm_wdata_q, ribm_wdata_d;
    logic            ribm_req_q, ribm_req_d;
    logic            ribm_rdy_q, ribm_rdy_d;

    logic [AW-1:0]   fifo_addr_q  [DEPTH];
    logic [3:0]      fifo_mask_q  [DEPTH];
    logic [31:0]     fifo_wdata_q [DEPTH];

    logic            fifo_full;
    logic            fifo_empty;
    logic            rsp_done;
    logic            pend_eff;
    logic            wr_gnt;
    logic            rd_gnt;
    logic            push;
    logic            pop;
    logic            rd_ret;
    logic [AW-1:0]   head_addr;
    logic [3:0]      head_mask;
    logic [31:0]     head_wdata;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign rsp_done   = ribs_rsp_q & bus.i_ribs_rdy;
    // A response retiring this cycle frees the single outstanding slot immediately.
    assign pend_eff   = rsp_pend_q & ~rsp_done;
    assign wr_gnt     = bus.i_ribs_req & bus.i_ribs_wrcs & ~fifo_full & ~pend_eff;
    assign rd_gnt     = bus.i_ribs_req & ~bus.i_ribs_wrcs & ~pend_eff & fifo_empty
                        & (state_q == ST_IDLE);
    assign push       = wr_gnt;

    // An empty FIFO forwards the incoming write so the drain starts one cycle after push.
    always_comb begin
        head_addr  = bus.i_ribs_addr;
        head_mask  = bus.i_ribs_mask;
        head_wdata = bus.i_ribs_wdata;
        if (!fifo_empty) begin
            head_addr  = fifo_addr_q[rd_ptr_q];
            head_mask  = fifo_mask_q[rd_ptr_q];
            head_wdata = fifo_wdata_q[rd_ptr_q];
        end
    end

    always_comb begin
        state_d      = state_q;
        ribm_addr_d  = ribm_addr_q;
        ribm_wrcs_d  = ribm_wrcs_q;
        ribm_mask_d  = ribm_mask_q;
        ribm_wdata_d = ribm_wdata_q;
        ribm_req_d   = ribm_req_q;
        ribm_rdy_d   = ribm_rdy_q;
        pop          = 1'b0;
        rd_ret       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty || push) begin
                    ribm_addr_d  = head_addr;
                    ribm_wrcs_d  = 1'b1;
                    ribm_mask_d  = head_mask;
                    ribm_wdata_d = head_wdata;
                    ribm_req_d   = 1'b1;
                    state_d      = ST_WR_REQ;
                end else if (rd_gnt) begin
                    ribm_addr_d  = bus.i_ribs_addr;
                    ribm_wrcs_d  = 1'b0;
                    ribm_mask_d  = 4'hF;
                    ribm_wdata_d = '0;
                    ribm_req_d   = 1'b1;
                    state_d      = ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                if (bus.i_ribm_gnt) begin
                    pop        = 1'b1;
                    ribm_req_d = 1'b0;
                    ribm_rdy_d = 1'b1;
                    state_d    = ST_WR_RSP;
                end
            end
            ST_WR_RSP: begin
                if (bus.i_ribm_rsp) begin
                    ribm_rdy_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (bus.i_ribm_gnt) begin
                    ribm_req_d = 1'b0;
                    ribm_rdy_d = 1'b1;
                    state_d    = ST_RD_RSP;
                end
            end
            ST_RD_RSP: begin
                if (bus.i_ribm_rsp) begin
                    ribm_rdy_d = 1'b0;
                    rd_ret     = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Retire first, then a back-to-back write or a read return may re-arm the response.
    always_comb begin
        ribs_rsp_d   = ribs_rsp_q;
        rsp_pend_d   = rsp_pend_q;
        ribs_rdata_d = ribs_rdata_q;
        if (rsp_done) begin
            ribs_rsp_d   = 1'b0;
            rsp_pend_d   = 1'b0;
            ribs_rdata_d = '0;
        end
        if (wr_gnt) begin
            ribs_rsp_d   = 1'b1;
            rsp_pend_d   = 1'b1;
            ribs_rdata_d = '0;
        end
        if (rd_gnt) begin
            rsp_pend_d = 1'b1;
        end
        if (rd_ret) begin
            ribs_rsp_d   = 1'b1;
            ribs_rdata_d = bus.i_ribm_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_pend_q   <= 1'b0;
            ribs_rsp_q   <= 1'b0;
            ribs_rdata_q <= '0;
            ribm_addr_q  <= '0;
            ribm_wrcs_q  <= 1'b0;
            ribm_mask_q  <= '0;
            ribm_wdata_q <= '0;
            ribm_req_q   <= 1'b0;
            ribm_rdy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rsp_pend_q   <= rsp_pend_d;
            ribs_rsp_q   <= ribs_rsp_d;
            ribs_rdata_q <= ribs_rdata_d;
            ribm_addr_q  <= ribm_addr_d;
            ribm_wrcs_q  <= ribm_wrcs_d;
            ribm_mask_q  <= ribm_mask_d;
            ribm_wdata_q <= ribm_wdata_d;
            ribm_req_q   <= ribm_req_d;
            ribm_rdy_q   <= ribm_rdy_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= bus.i_ribs_addr;
            fifo_mask_q[wr_ptr_q]  <= bus.i_ribs_mask;
            fifo_wdata_q[wr_ptr_q] <= bus.i_ribs_wdata;
        end
    end

    assign bus.o_ribs_gnt   = wr_gnt | rd_gnt;
    assign bus.o_ribs_rsp   = ribs_rsp_q;
    assign bus.o_ribs_rdata = ribs_rdata_q;
    assign bus.o_ribm_addr  = ribm_addr_q;
    assign bus.o_ribm_wrcs  = ribm_wrcs_q;
    assign bus.o_ribm_mask  = ribm_mask_q;
    assign bus.o_ribm_wdata = ribm_wdata_q;
    assign bus.o_ribm_req   = ribm_req_q;
    assign bus.o_ribm_rdy   = ribm_rdy_q;
    assign o_wbuf_empty     = fifo_empty & (state_q == ST_IDLE);
endmodule

// File: tb/tb_rib_sdram_wbuf.sv
// tb/tb_rib_sdram_wbuf.sv - directed table and sequence bench for rib_sdram_wbuf
// One table row per clock cycle; multi-cycle ordering, refresh stall and reset cases follow by hand.
module tb_rib_sdram_wbuf;
    logic clk;
    logic rst;
    logic wbuf_empty;

    rib_sdram_wbuf_if #(.AW(32)) bus ();

    rib_sdram_wbuf #(.DEPTH(4), .AW(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus.slave),
        .o_wbuf_empty (wbuf_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        req;
        logic        wrcs;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        s_rdy;
        logic        m_gnt;
        logic        m_rsp;
        logic        e_gnt;
        logic        e_rsp;
        logic        e_mreq;
        logic        e_mrdy;
        logic        e_empty;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];

    function automatic vec_t mk(logic req, logic wrcs, logic [31:0] addr, logic [31:0] wdata,
                                logic s_rdy, logic m_gnt, logic m_rsp,
                                logic e_gnt, logic e_rsp, logic e_mreq, logic e_mrdy,
                                logic e_empty, logic [31:0] e_maddr, logic [31:0] e_mwdata);
        vec_t v;
        v.req = req; v.wrcs = wrcs; v.addr = addr; v.wdata = wdata;
        v.s_rdy = s_rdy; v.m_gnt = m_gnt; v.m_rsp = m_rsp;
        v.e_gnt = e_gnt; v.e_rsp = e_rsp; v.e_mreq = e_mreq; v.e_mrdy = e_mrdy;
        v.e_empty = e_empty; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_up(logic req, logic wrcs, logic [31:0] addr, logic [31:0] wdata, logic s_rdy);
        bus.i_ribs_req   = req;
        bus.i_ribs_wrcs  = wrcs;
        bus.i_ribs_addr  = addr;
        bus.i_ribs_wdata = wdata;
        bus.i_ribs_mask  = 4'hF;
        bus.i_ribs_rdy   = s_rdy;
    endtask

    task automatic drive_dn(logic m_gnt, logic m_rsp, logic [31:0] m_rdata);
        bus.i_ribm_gnt   = m_gnt;
        bus.i_ribm_rsp   = m_rsp;
        bus.i_ribm_rdata = m_rdata;
    endtask

    task automatic drain(string tag);
        bit done = 0;
        wr_t w;
        for (int c = 0; c < 64 && !done; c++) begin
            cyc();
            drive_up(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            drive_dn(1'b1, 1'b1, 32'h0);
            #2;
            if (bus.o_ribm_req) begin
                if (exp_q.size() == 0) begin
                    chk({tag, " extra write"}, bus.o_ribm_addr, 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk({tag, " drain addr"}, bus.o_ribm_addr, w.addr);
                    chk({tag, " drain data"}, bus.o_ribm_wdata, w.data);
                    chk({tag, " drain wrcs"}, 32'(bus.o_ribm_wrcs), 32'h1);
                end
            end
            if (exp_q.size() == 0 && wbuf_empty) done = 1;
        end
        chk({tag, " drain finished"}, 32'(done), 32'h1);
        chk({tag, " drain left"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Test 1: single write and drain
        tbl.push_back(mk(0,0,32'h0,32'h0,               1,1,0, 0,0,0,0,1, 32'h0,32'h0));
        tbl.push_back(mk(1,1,32'h100,32'hDEADBEEF,      1,1,0, 1,0,0,0,1, 32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,32'h0,               1,1,0, 0,1,1,0,0, 32'h100,32'hDEADBEEF));
        tbl.push_back(mk(0,0,32'h0,32'h0,               1,1,1, 0,0,0,1,0, 32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,32'h0,               1,0,0, 0,0,0,0,1, 32'h0,32'h0));
        // Test 2: fill DEPTH=4 under a stalled slave, 5th write waits for the first pop
        tbl.push_back(mk(1,1,32'h10,32'h1,              1,0,0, 1,0,0,0,1, 32'h0,32'h0));
        tbl.push_back(mk(1,1,32'h14,32'h2,              1,0,0, 1,1,1,0,0, 32'h10,32'h1));
        tbl.push_back(mk(1,1,32'h18,32'h3,              1,0,0, 1,1,1,0,0, 32'h10,32'h1));
        tbl.push_back(mk(1,1,32'h1C,32'h4,              1,0,0, 1,1,1,0,0, 32'h10,32'h1));
        tbl.push_back(mk(1,1,32'h20,32'h5,              1,0,0, 0,1,1,0,0, 32'h10,32'h1));
        tbl.push_back(mk(1,1,32'h20,32'h5,              1,1,0, 0,0,1,0,0, 32'h10,32'h1));
        tbl.push_back(mk(1,1,32'h20,32'h5,              1,1,0, 1,0,0,1,0, 32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,32'h0,               1,0,1, 0,1,0,1,0, 32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,32'h0,               1,0,0, 0,0,0,0,0, 32'h0,32'h0));
        tbl.push_back(mk(0,0,32'h0,32'h0,               1,0,0, 0,0,1,0,0, 32'h14,32'h2));

        rst = 1'b1;
        drive_up(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_dn(1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("reset gnt",    32'(bus.o_ribs_gnt),  32'h0);
        chk("reset rsp",    32'(bus.o_ribs_rsp),  32'h0);
        chk("reset rdata",  bus.o_ribs_rdata,     32'h0);
        chk("reset mreq",   32'(bus.o_ribm_req),  32'h0);
        chk("reset maddr",  bus.o_ribm_addr,      32'h0);
        chk("reset mwdata", bus.o_ribm_wdata,     32'h0);
        chk("reset mwrcs",  32'(bus.o_ribm_wrcs), 32'h0);
        chk("reset mmask",  32'(bus.o_ribm_mask), 32'h0);
        chk("reset mrdy",   32'(bus.o_ribm_rdy),  32'h0);
        chk("reset empty",  32'(wbuf_empty),      32'h1);

        foreach (tbl[i]) begin
            cyc();
            drive_up(tbl[i].req, tbl[i].wrcs, tbl[i].addr, tbl[i].wdata, tbl[i].s_rdy);
            drive_dn(tbl[i].m_gnt, tbl[i].m_rsp, 32'h0);
            #2;
            chk($sformatf("row%0d gnt", i),   32'(bus.o_ribs_gnt), 32'(tbl[i].e_gnt));
            chk($sformatf("row%0d rsp", i),   32'(bus.o_ribs_rsp), 32'(tbl[i].e_rsp));
            chk($sformatf("row%0d mreq", i),  32'(bus.o_ribm_req), 32'(tbl[i].e_mreq));
            chk($sformatf("row%0d mrdy", i),  32'(bus.o_ribm_rdy), 32'(tbl[i].e_mrdy));
            chk($sformatf("row%0d empty", i), 32'(wbuf_empty),     32'(tbl[i].e_empty));
            if (tbl[i].e_mreq) begin
                chk($sformatf("row%0d maddr", i),  bus.o_ribm_addr,      tbl[i].e_maddr);
                chk($sformatf("row%0d mwdata", i), bus.o_ribm_wdata,     tbl[i].e_mwdata);
                chk($sformatf("row%0d mmask", i),  32'(bus.o_ribm_mask), 32'hF);
            end
        end

        exp_q.push_back('{32'h14, 32'h2});
        exp_q.push_back('{32'h18, 32'h3});
        exp_q.push_back('{32'h1C, 32'h4});
        exp_q.push_back('{32'h20, 32'h5});
        drain("t2");

        // Test 3: read-after-write ordering
        cyc();
        drive_up(1'b1, 1'b1, 32'h200, 32'h11223344, 1'b1);
        drive_dn(1'b0, 1'b0, 32'h0);
        #2;
        chk("t3 write gnt", 32'(bus.o_ribs_gnt), 32'h1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            drive_up(1'b1, 1'b0, 32'h200, 32'h0, 1'b1);
            #2;
            chk($sformatf("t3 rd blocked fifo %0d", k), 32'(bus.o_ribs_gnt), 32'h0);
            chk($sformatf("t3 mreq %0d", k),            32'(bus.o_ribm_req), 32'h1);
        end
        cyc();
        drive_dn(1'b1, 1'b0, 32'h0);
        #2;
        chk("t3 rd blocked wr_req", 32'(bus.o_ribs_gnt), 32'h0);
        cyc();
        drive_dn(1'b0, 1'b0, 32'h0);
        #2;
        chk("t3 rd blocked wr_rsp", 32'(bus.o_ribs_gnt), 32'h0);
        chk("t3 mrdy wr_rsp",       32'(bus.o_ribm_rdy), 32'h1);
        cyc();
        drive_dn(1'b0, 1'b1, 32'h0);
        #2;
        chk("t3 rd blocked rsp cycle", 32'(bus.o_ribs_gnt), 32'h0);
        cyc();
        drive_dn(1'b0, 1'b0, 32'h0);
        #2;
        chk("t3 rd gnt", 32'(bus.o_ribs_gnt), 32'h1);
        cyc();
        drive_up(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        drive_dn(1'b1, 1'b0, 32'h0);
        #2;
        chk("t3 rd mreq",  32'(bus.o_ribm_req),  32'h1);
        chk("t3 rd mwrcs", 32'(bus.o_ribm_wrcs), 32'h0);
        chk("t3 rd mmask", 32'(bus.o_ribm_mask), 32'hF);
        chk("t3 rd maddr", bus.o_ribm_addr,      32'h200);
        cyc();
        drive_up(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive_dn(1'b0, 1'b1, 32'h11223344);
        #2;
        chk("t3 rd mrdy",      32'(bus.o_ribm_rdy), 32'h1);
        chk("t3 rsp not yet",  32'(bus.o_ribs_rsp), 32'h0);

        // Test 5: read response held while upstream not ready
        for (int k = 0; k < 3; k++) begin
            cyc();
            drive_up(1'b1, 1'b1, 32'h300, 32'hA5A50001, 1'b0);
            drive_dn(1'b0, 1'b0, 32'h0);
            #2;
            chk($sformatf("t5 rsp held %0d", k),   32'(bus.o_ribs_rsp), 32'h1);
            chk($sformatf("t5 rdata held %0d", k), bus.o_ribs_rdata,    32'h11223344);
            chk($sformatf("t5 no gnt %0d", k),     32'(bus.o_ribs_gnt), 32'h0);
        end
        cyc();
        drive_up(1'b1, 1'b1, 32'h300, 32'hA5A50001, 1'b1);
        #2;
        chk("t5 rsp at rdy",    32'(bus.o_ribs_rsp), 32'h1);
        chk("t5 rdata at rdy",  bus.o_ribs_rdata,    32'h11223344);
        chk("t5 b2b write gnt", 32'(bus.o_ribs_gnt), 32'h1);

        // Test 4: refresh stall, three more writes queue behind the stalled head
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k < 3) drive_up(1'b1, 1'b1, 32'h304 + 32'(4 * k), 32'hB0 + 32'(k), 1'b1);
            else       drive_up(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            #2;
            if (k == 0) chk("t4 write rdata zero", bus.o_ribs_rdata, 32'h0);
            if (k < 3)  chk($sformatf("t4 queue gnt %0d", k), 32'(bus.o_ribs_gnt), 32'h1);
            chk($sformatf("t4 mreq %0d", k),   32'(bus.o_ribm_req), 32'h1);
            chk($sformatf("t4 maddr %0d", k),  bus.o_ribm_addr,     32'h300);
            chk($sformatf("t4 mwdata %0d", k), bus.o_ribm_wdata,    32'hA5A50001);
        end
        cyc();
        drive_dn(1'b1, 1'b0, 32'h0);
        #2;
        chk("t4 mreq at gnt", 32'(bus.o_ribm_req), 32'h1);

        // Test 6: reset in WR_RSP with three entries still queued
        cyc();
        drive_dn(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #2;
        chk("t6 in wr_rsp", 32'(bus.o_ribm_rdy), 32'h1);
        chk("t6 not empty", 32'(wbuf_empty),     32'h0);
        cyc();
        rst = 1'b0;
        #2;
        chk("t6 mreq",  32'(bus.o_ribm_req), 32'h0);
        chk("t6 mrdy",  32'(bus.o_ribm_rdy), 32'h0);
        chk("t6 empty", 32'(wbuf_empty),     32'h1);
        chk("t6 rsp",   32'(bus.o_ribs_rsp), 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            drive_dn(1'b1, 1'b1, 32'h0);
            #2;
            chk($sformatf("t6 no drain %0d", k), 32'(bus.o_ribm_req), 32'h0);
            chk($sformatf("t6 stays empty %0d", k), 32'(wbuf_empty), 32'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
